lsu_mmio: RTL and testbench
===========================

Name: lsu_mmio

Overview:
- Parametrised load/store unit for the pipeline MEM stage.
- Contains byte-addressable data memory, N_OUT memory-mapped 32-bit output registers and a synchronised switch input port.
- Supports LB/LBU/LH/LHU/LW and SB/SH/SW with true byte-lane writes, sign/zero extension, alignment and region fault detection.
- Every request gets a registered response exactly one cycle later.

Parameters:
- ADDR_W, 12: byte address width.
- DMEM_BYTES, 1024: data memory size in bytes; power of 2, at least 4; occupies 0 .. DMEM_BYTES-1.
- IO_BASE, 12'h400: base of output registers; register k sits at IO_BASE + 16*k.
- N_OUT, 11: number of output registers, 1..16.
- SW_BASE, 12'h500: switch input word address (word-aligned).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_i  in  1  access request this cycle.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_i  in  1  1 = zero-extend loads.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, LSB-aligned.
- io_sw_i  in  32  asynchronous switch inputs.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  load result.
- err_o  out  1  access fault, qualified by rvalid_o.
- io_out_o  out  32*N_OUT  output registers; register k occupies bits [32k+31:32k].

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
  - In reset: rvalid_o=0, rdata_o=0, err_o=0, all io_out_o=0, switch sync flops=0.
  - Data memory array is not reset; its contents are retained across reset.
- Always ready; one request accepted per cycle when req_i=1.
- Latency: response for a request accepted at edge N appears after edge N+1.
  - rvalid_o=1 for exactly one cycle per request, for loads and stores alike.
  - With no request, rvalid_o=0, and rdata_o and err_o are forced to 0.
- Region decode on the word address (addr_i with [1:0] cleared):
  - DMEM: address < DMEM_BYTES.
  - OUTk: address == IO_BASE + 16*k, for k < N_OUT.
  - SW: address == SW_BASE.
  - Anything else is unmapped.
- Fault: err_o=1 when any of the following holds:
  - size_i=11;
  - half access with addr_i[0]=1;
  - word access with addr_i[1:0]≠0;
  - unmapped address;
  - store to SW.
- On fault: no state changes, rdata_o=0.
- Stores: write byte lanes only; untouched bytes keep their old values.
  - Byte lane = addr_i[1:0].
  - SB writes wdata_i[7:0] to that lane.
  - SH writes wdata_i[15:0] to lanes addr_i[1]*2 .. +1.
  - SW writes all four lanes.
  - Byte-lane writes apply identically to DMEM and OUTk.
- Loads: read the 32-bit word, select lane(s) by addr_i[1:0], then extend.
  - Sign-extend when unsigned_i=0, zero-extend when unsigned_i=1.
  - unsigned_i is ignored for word loads.
- Switch path: io_sw_i passes through a 2-flop synchroniser.
  - SW reads return the second flop's value at the load's edge, so a switch change becomes visible to loads 2 cycles later.
- Store then load to the same address on consecutive cycles: the load returns the new data (write completes at edge N; read at edge N+1).
- Reset asserted mid-operation: any pending response is dropped (rvalid_o=0), and a store in flight at the reset edge does not take effect on io_out_o.
- Little-endian throughout.

Test Plan:
- SW 0x8765_4321 @0x010, then LW @0x010 → rvalid_o one cycle after each request; load rdata_o=0x87654321, err_o=0.
- After the above, SB 0xAA @0x012, then LW @0x010 → 0x87AA4321.
  - LB @0x012 → 0xFFFFFFAA.
  - LBU @0x012 → 0x000000AA.
  - LH @0x012 → 0xFFFF87AA.
- SW 0x0000_00FF @0x430 (OUT3) → io_out_o[127:96]=0x000000FF on the following cycle; other registers unchanged. Then SH 0x1234 @0x432 → OUT3=0x123400FF.
- LW @0x011, LH @0x013, SW @0x600, SW @0x500 → each gives err_o=1, rdata_o=0; memory, outputs and a subsequent LW @0x010 are unchanged.
- io_sw_i changes to 0x0000_0155 at cycle C → LW @0x500 issued at edge C+1 returns the old value; issued at edge C+2 or later returns 0x155.
- Pulse rst_ni low after writing OUT0 and DMEM @0x010 → io_out_o all 0 and rvalid_o=0 immediately (asynchronous); LW @0x010 after reset still returns the pre-reset data.

Source files
------------

// File: rtl/lsu_mmio.sv
// Load/store unit for the MEM stage: byte-addressable data memory, memory-mapped
// output registers and a synchronised switch port, answered one cycle after each request.
module lsu_mmio #(
    parameter int                ADDR_W     = 12,
    parameter int                DMEM_BYTES = 1024,
    parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'('h400),
    parameter int                N_OUT      = 11,
    parameter logic [ADDR_W-1:0] SW_BASE    = ADDR_W'('h500)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [31:0]         wdata_i,
    input  logic [31:0]         io_sw_i,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    output logic [32*N_OUT-1:0] io_out_o
);

    localparam int              MEM_WORDS = DMEM_BYTES / 4;
    localparam int              MEM_IW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int              OUT_IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [ADDR_W:0] DMEM_LIM  = (ADDR_W + 1)'(DMEM_BYTES);

    // Replace only the addressed byte lanes of the old word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        logic [4:0]  shamt;
        case (size)
            2'b00:   begin shamt = {lane, 3'b000};       mask = 32'h0000_00ff << shamt; end
            2'b01:   begin shamt = {lane[1], 4'b0000};   mask = 32'h0000_ffff << shamt; end
            default: begin shamt = 5'd0;                 mask = 32'hffff_ffff;          end
        endcase
        return (old_word & ~mask) | ((wdata << shamt) & mask);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        is_unsigned);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {lane, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        case (size)
            2'b00:   return is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    logic [31:0]       mem [MEM_WORDS];
    logic [31:0]       out_q [N_OUT];
    logic [31:0]       sw_p1, sw_p2;

    logic [ADDR_W-1:0] waddr_p0;
    logic              hit_mem_p0, hit_out_p0, hit_sw_p0, fault_p0, wr_p0;
    logic [OUT_IW-1:0] out_idx_p0;
    logic [MEM_IW-1:0] mem_idx_p0;
    logic [31:0]       word_p0, merged_p0, load_p0;

    logic              vld_p1, err_p1;
    logic [31:0]       rdata_p1;

    // Stage p0: decode, fault check, read-modify-write data
    always_comb begin
        waddr_p0   = {addr_i[ADDR_W-1:2], 2'b00};
        hit_mem_p0 = ({1'b0, waddr_p0} < DMEM_LIM);
        hit_out_p0 = 1'b0;
        out_idx_p0 = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (!hit_mem_p0 && waddr_p0 == IO_BASE + ADDR_W'(k * 16)) begin
                hit_out_p0 = 1'b1;
                out_idx_p0 = OUT_IW'(k);
            end
        end
        hit_sw_p0  = !hit_mem_p0 && !hit_out_p0 && (waddr_p0 == SW_BASE);
        mem_idx_p0 = MEM_IW'(addr_i >> 2);

        if (hit_mem_p0)      word_p0 = mem[mem_idx_p0];
        else if (hit_out_p0) word_p0 = out_q[out_idx_p0];
        else if (hit_sw_p0)  word_p0 = sw_p2;
        else                 word_p0 = 32'd0;

        fault_p0 = (size_i == 2'b11)
                 || (size_i == 2'b01 && addr_i[0])
                 || (size_i == 2'b10 && addr_i[1:0] != 2'b00)
                 || !(hit_mem_p0 || hit_out_p0 || hit_sw_p0)
                 || (we_i && hit_sw_p0);
        wr_p0     = req_i && we_i && !fault_p0;
        merged_p0 = lane_merge(word_p0, wdata_i, size_i, addr_i[1:0]);
        load_p0   = load_extend(word_p0, size_i, addr_i[1:0], unsigned_i);
    end

    // Data memory is deliberately not reset so its contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (wr_p0 && hit_mem_p0) mem[mem_idx_p0] <= merged_p0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_OUT; k++) out_q[k] <= 32'd0;
        end else if (wr_p0 && hit_out_p0) begin
            out_q[out_idx_p0] <= merged_p0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_p1 <= 32'd0;
            sw_p2 <= 32'd0;
        end else begin
            sw_p1 <= io_sw_i;
            sw_p2 <= sw_p1;
        end
    end

    // Stage p1: registered response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= 32'd0;
        end else begin
            vld_p1   <= req_i;
            err_p1   <= req_i && fault_p0;
            rdata_p1 <= (req_i && !we_i && !fault_p0) ? load_p0 : 32'd0;
        end
    end

    assign rvalid_o = vld_p1;
    assign err_o    = err_p1;
    assign rdata_o  = rdata_p1;

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign io_out_o[32*g +: 32] = out_q[g];
    end

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio: directed vector table, multi-cycle corner
// sequences, and random traffic against a byte-level reference model.
module tb_lsu_mmio;

    localparam int NO = 11;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req = 1'b0, we = 1'b0, uns = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [11:0]   addr = '0;
    logic [31:0]   wdata = '0, io_sw = '0;
    logic          rvalid, err;
    logic [31:0]   rdata;
    logic [32*NO-1:0] io_out;

    lsu_mmio dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .size_i(size),
        .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .io_sw_i(io_sw),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .io_out_o(io_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: bytes of data memory, output register words, visible switch word.
    logic [7:0]  dm [1024];
    logic [31:0] om [NO];
    logic [31:0] sw_vis = '0;

    typedef struct {
        bit          we;
        logic [1:0]  sz;
        bit          u;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        bit          ee;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        for (int k = 0; k < NO; k++)
            chk($sformatf("%s_out%0d", tag, k), io_out[32*k +: 32], om[k]);
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] er, input bit ee);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk({tag, "_rdata"}, rdata, er);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    endtask

    // Applies the access rules byte by byte to the model state.
    task automatic model(input bit w, input logic [1:0] sz, input bit u, input logic [11:0] a,
                         input logic [31:0] wd, output logic [31:0] er, output bit ee);
        int wa, off, kind, k, nb;
        logic [31:0] v;
        logic [7:0]  b;
        wa = int'(a) & ~3;
        off = int'(a) & 3;
        k = 0;
        if (wa < 1024) kind = 1;
        else if (wa >= 'h400 && (wa - 'h400) % 16 == 0 && (wa - 'h400) / 16 < NO) begin
            kind = 2;
            k = (wa - 'h400) / 16;
        end
        else if (wa == 'h500) kind = 3;
        else kind = 0;
        ee = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0)
          || kind == 0 || (w && kind == 3);
        er = '0;
        if (ee) return;
        nb = 1 << sz;
        if (w) begin
            for (int i = 0; i < nb; i++) begin
                b = wd[8*i +: 8];
                if (kind == 1) dm[wa + off + i] = b;
                else om[k][8*(off + i) +: 8] = b;
            end
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) begin
                if (kind == 1)      b = dm[wa + off + i];
                else if (kind == 2) b = om[k][8*(off + i) +: 8];
                else                b = sw_vis[8*(off + i) +: 8];
                v[8*i +: 8] = b;
            end
            if (nb < 4 && !u && v[8*nb - 1])
                for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
            er = v;
        end
    endtask

    task automatic step(input bit w, input logic [1:0] sz, input bit u, input logic [11:0] a,
                        input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit w, input logic [1:0] sz, input bit u, input logic [11:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input bit ee);
        tbl.push_back('{w, sz, u, a, wd, er, ee});
    endtask

    task automatic mstep(input string tag, input bit w, input logic [1:0] sz, input bit u,
                         input logic [11:0] a, input logic [31:0] wd);
        logic [31:0] er;
        bit ee;
        model(w, sz, u, a, wd, er, ee);
        step(w, sz, u, a, wd);
        chk_resp(tag, er, ee);
        chk_out(tag);
    endtask

    initial begin
        logic [31:0] er_m;
        bit          ee_m;
        logic [11:0] ra;

        for (int k = 0; k < NO; k++) om[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk_out("rst");
        @(negedge clk);
        rst_ni = 1'b1;
        idle();
        chk("idle_rvalid", {31'd0, rvalid}, 32'd0);

        // Directed vector table
        add(1, 2, 0, 'h010, 'h8765_4321, 'h0, 0);
        add(0, 2, 0, 'h010, 'h0, 'h8765_4321, 0);
        add(1, 0, 0, 'h012, 'hAA, 'h0, 0);
        add(0, 2, 0, 'h010, 'h0, 'h87AA_4321, 0);
        add(0, 0, 0, 'h012, 'h0, 'hFFFF_FFAA, 0);
        add(0, 0, 1, 'h012, 'h0, 'h0000_00AA, 0);
        add(0, 1, 0, 'h012, 'h0, 'hFFFF_87AA, 0);
        add(0, 1, 1, 'h012, 'h0, 'h0000_87AA, 0);
        add(1, 2, 0, 'h430, 'h0000_00FF, 'h0, 0);
        add(1, 1, 0, 'h432, 'h1234, 'h0, 0);
        add(0, 2, 0, 'h430, 'h0, 'h1234_00FF, 0);
        add(0, 0, 0, 'h433, 'h0, 'h0000_0012, 0);
        add(0, 0, 0, 'h431, 'h0, 'h0, 0);
        add(0, 2, 0, 'h011, 'h0, 'h0, 1);
        add(0, 1, 0, 'h013, 'h0, 'h0, 1);
        add(1, 2, 0, 'h600, 'hFFFF_FFFF, 'h0, 1);
        add(1, 2, 0, 'h500, 'hFFFF_FFFF, 'h0, 1);
        add(1, 3, 0, 'h010, 'hFFFF_FFFF, 'h0, 1);
        add(1, 2, 0, 'h4B0, 'h1, 'h0, 1);
        add(1, 2, 0, 'h4A0, 'hDEAD_BEEF, 'h0, 0);
        add(0, 2, 1, 'h4A0, 'h0, 'hDEAD_BEEF, 0);
        add(0, 2, 0, 'h010, 'h0, 'h87AA_4321, 0);
        add(1, 0, 0, 'h3FF, 'h80, 'h0, 0);
        add(0, 0, 0, 'h3FF, 'h0, 'hFFFF_FF80, 0);
        add(0, 0, 1, 'h3FF, 'h0, 'h0000_0080, 0);
        add(1, 1, 0, 'h3FD, 'h5555, 'h0, 1);
        add(0, 0, 0, 'h42C, 'h0, 'h0, 1);
        add(0, 2, 0, 'h500, 'h0, 'h0, 0);
        add(1, 1, 0, 'h012, 'hBEEF, 'h0, 0);
        add(0, 2, 0, 'h010, 'h0, 'hBEEF_4321, 0);
        add(0, 1, 0, 'h010, 'h0, 'h0000_4321, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            model(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, er_m, ee_m);
            step(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd);
            chk_resp($sformatf("vec%0d", i), tbl[i].er, tbl[i].ee);
            chk_out($sformatf("vec%0d", i));
        end
        idle();
        chk("noreq_rvalid", {31'd0, rvalid}, 32'd0);
        chk("noreq_rdata", rdata, 32'd0);
        chk("noreq_err", {31'd0, err}, 32'd0);

        // Switch synchroniser: change lands during cycle C
        @(negedge clk);
        io_sw = 32'h0000_0155;
        step(0, 2, 0, 'h500, 'h0);
        chk_resp("sw_old", 32'h0, 0);
        step(0, 2, 0, 'h500, 'h0);
        chk_resp("sw_new", 32'h0000_0155, 0);
        step(0, 0, 0, 'h500, 'h0);
        chk_resp("sw_lb", 32'h0000_0055, 0);
        sw_vis = 32'h0000_0155;

        // Asynchronous reset mid-operation
        mstep("pre_rst", 1, 2, 0, 'h400, 'h1122_3344);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 'h010;
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        for (int k = 0; k < NO; k++) om[k] = '0;
        #1;
        chk("arst_rvalid", {31'd0, rvalid}, 32'd0);
        chk_out("arst");
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 'h410; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("inrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk_out("inrst");
        @(negedge clk);
        req = 1'b0;
        rst_ni = 1'b1;
        sw_vis = '0;
        step(0, 2, 0, 'h500, 'h0);
        chk_resp("post_rst_sw", 32'h0, 0);
        chk_out("post_rst");
        mstep("post_rst_dm", 0, 2, 0, 'h010, 'h0);
        idle();
        idle();
        sw_vis = io_sw;

        // Random traffic against the model
        io_sw = $urandom;
        repeat (3) idle();
        sw_vis = io_sw;
        for (int a = 0; a < 128; a += 4) mstep("init", 1, 2, 0, 12'(a), $urandom);
        for (int a = 'h3F0; a < 'h400; a += 4) mstep("init", 1, 2, 0, 12'(a), $urandom);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    ra = 12'($urandom_range(0, 127));
                2:       ra = 12'('h3F0 + $urandom_range(0, 15));
                3:       ra = 12'('h400 + 16 * $urandom_range(0, 11) + $urandom_range(0, 7));
                4:       ra = 12'('h500 + $urandom_range(0, 3));
                default: ra = 12'('h600 + $urandom_range(0, 511));
            endcase
            mstep($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ra, $urandom);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
